cell_grid_stream_gen: RTL and testbench
=======================================

Name: cell_grid_stream_gen

Overview:
- Parametrised successor to the fixed 1280x720 cell-display pixel generator.
- Renders a grid of cells to an AXI4-Stream video output, one pixel per beat: each cell becomes a CELL_SIZE x CELL_SIZE block of pixels.
- Fetches one cell row at a time from an external row store through a request/response handshake, and prefetches the next cell row into a double buffer.
- Supports 1- or 2-bit cells with a 4-entry colour palette that is sampled once per frame; sits between the cell-state row memory and the VDMA/video stream path.

Parameters:
- X_CELLS, 64, cells per row.
- Y_CELLS, 36, cell rows per frame.
- CELL_SIZE, 20, pixels per cell edge; frame is X_CELLS*CELL_SIZE by Y_CELLS*CELL_SIZE.
- BPC, 1, bits per cell (1 or 2); row word width RW = X_CELLS*BPC.
- PIX_W, 24, pixel width; tdata = {r,g,b}.

Ports:
- out_stream_aclk  in  1  sole clock.
- periph_reset  in  1  synchronous, active-high reset.
- enable  in  1  run request, checked only at frame boundaries.
- palette  in  4*PIX_W  entry k at [k*PIX_W +: PIX_W]; BPC=1 uses entries 0 and 1.
- row_req_valid  out  1  cell-row fetch request.
- row_req_ready  in  1  store accepts the request.
- row_req_addr  out  clog2(Y_CELLS)  cell row index.
- row_rsp_valid  in  1  single-cycle pulse carrying row data.
- row_rsp_data  in  RW  cell c occupies [(X_CELLS-1-c)*BPC +: BPC], so cell 0 is in the MSBs.
- out_stream_tdata  out  PIX_W  pixel value.
- out_stream_tvalid  out  1  pixel valid.
- out_stream_tready  in  1  downstream ready.
- out_stream_tlast  out  1  last pixel of a line.
- out_stream_tuser  out  1  first pixel of a frame.
- frame_done  out  1  one-cycle pulse after the last beat of a frame.
- underrun_count  out  16  saturating count of stall cycles where a row was not ready.

Behaviour:
- Reset values, applied in the cycle periph_reset is sampled high: all outputs 0, all counters 0, both row buffers marked empty, fetch FSM in F_IDLE, render FSM in R_IDLE.
- Reset asserted mid-frame or mid-fetch abandons the frame. A row_rsp_valid pulse arriving after reset is ignored unless a request is outstanding.
- Fetch FSM:
  - F_IDLE -> F_REQ when the next buffer is empty and the render FSM requires a row.
  - F_REQ holds row_req_valid=1 with a stable row_req_addr until row_req_ready; the transfer completes in that cycle, then -> F_WAIT.
  - F_WAIT: on row_rsp_valid, capture data into the next buffer, mark it full, -> F_IDLE.
  - Response latency is unbounded.
  - Only one request may be outstanding.
- Render FSM:
  - R_IDLE: when enable=1, latch palette into a shadow register, request cell row 0, -> R_LOAD.
  - R_LOAD: when the next buffer is full, swap it into the current buffer, mark next empty, -> R_ACTIVE. Immediately request cell row (cy+1) mod Y_CELLS.
  - R_ACTIVE streams pixels. Pixel (px,py) maps to cx = px/CELL_SIZE and cy = py/CELL_SIZE.
  - Use separate sub-cell counters; no dividers.
  - tdata = shadow_palette[cell value]; in BPC=1 mode the index is {1'b0,bit}.
- Stream handshake:
  - tvalid, once high, stays high with tdata, tlast and tuser stable until tready.
  - Counters advance only on tvalid&tready.
  - Output registers have one cycle of latency from entering R_ACTIVE.
- tuser=1 only on pixel (0,0). tlast=1 on px = X_CELLS*CELL_SIZE-1.
- Line end:
  - Same cell row (sub-row < CELL_SIZE-1): the next line starts on the next cycle with no bubble.
  - Crossing into a new cell row: if the next buffer is full, swap with no bubble. Otherwise drop tvalid, -> R_LOAD, and increment underrun_count every cycle spent waiting (saturating at 16'hFFFF).
- Frame end, after the last beat:
  - Pulse frame_done.
  - If enable=1, re-latch palette and continue with row 0; that row was already prefetched as (Y_CELLS-1)+1 wraps to 0.
  - If enable=0, -> R_IDLE and discard the prefetched row.
- enable deasserted mid-frame has no effect until the frame end.
- A palette change mid-frame has no effect until the next frame.

Test Plan:
- Defaults, BPC=1, row store with 2-cycle latency, tready held 1, row 0 = {1'b1, 63'b0}, palette[0]=24'h000000, palette[1]=24'hCB416B -> pixels 0..19 of lines 0..19 are CB416B and all others on those lines are 000000. tuser only on the first beat, tlast every 1280 beats, one frame_done after 921600 beats, underrun_count = 0.
- BPC=2, X_CELLS=4, Y_CELLS=2, CELL_SIZE=2, row = 8'b00_01_10_11 -> each line is p0,p0,p1,p1,p2,p2,p3,p3 with tlast on beat 7.
- Random tready at 50% -> tdata/tlast/tuser stable while tvalid&!tready, and the beat sequence is identical to the tready=1 run.
- Row store latency 3000 cycles -> tvalid drops at each cell-row boundary, underrun_count > 0, no pixel lost or duplicated.
- Palette changed and enable cleared mid-frame -> the current frame completes with the old colours, frame_done pulses, then tvalid=0 and row_req_valid=0.
- periph_reset asserted for one cycle mid-line with a request outstanding -> all outputs 0 next cycle. After restart, the first beat has tuser=1 and a stale row_rsp_valid is ignored.

Source files
------------

// File: rtl/cell_grid_stream_gen.sv
// cell_grid_stream_gen: renders a grid of 1- or 2-bit cells as an AXI4-Stream
// video frame. Each cell becomes a CELL_SIZE x CELL_SIZE block of pixels. Cell
// rows are fetched one at a time from an external store into a double buffer,
// and the next row is prefetched while the current one is drawn.
module cell_grid_stream_gen #(
    parameter int X_CELLS   = 64,
    parameter int Y_CELLS   = 36,
    parameter int CELL_SIZE = 20,
    parameter int BPC       = 1,
    parameter int PIX_W     = 24
) (
    input  logic                       out_stream_aclk,
    input  logic                       periph_reset,
    input  logic                       enable,
    input  logic [4*PIX_W-1:0]         palette,
    output logic                       row_req_valid,
    input  logic                       row_req_ready,
    output logic [$clog2(Y_CELLS)-1:0] row_req_addr,
    input  logic                       row_rsp_valid,
    input  logic [X_CELLS*BPC-1:0]     row_rsp_data,
    output logic [PIX_W-1:0]           out_stream_tdata,
    output logic                       out_stream_tvalid,
    input  logic                       out_stream_tready,
    output logic                       out_stream_tlast,
    output logic                       out_stream_tuser,
    output logic                       frame_done,
    output logic [15:0]                underrun_count
);
    localparam int RW  = X_CELLS * BPC;
    localparam int AW  = $clog2(Y_CELLS);
    localparam int CXW = (X_CELLS > 1) ? $clog2(X_CELLS) : 1;
    localparam int CSW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;

    typedef enum logic [1:0] {F_IDLE = 2'd0, F_REQ = 2'd1, F_WAIT = 2'd2} f_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_ACTIVE = 2'd2, R_DRAIN = 2'd3} r_state_e;

    f_state_e           f_state_q, f_state_d;
    r_state_e           r_state_q, r_state_d;
    logic               req_valid_q, req_valid_d;
    logic [AW-1:0]      req_addr_q, req_addr_d;
    logic [AW-1:0]      fetch_addr_q, fetch_addr_d;   // next cell row to prefetch
    logic               need_row_q, need_row_d;       // render wants fetch_addr fetched
    logic               drop_rsp_q, drop_rsp_d;       // outstanding response belongs to an abandoned frame
    logic               nxt_full_q, nxt_full_d;
    logic [RW-1:0]      nxt_buf_q, nxt_buf_d;
    logic [RW-1:0]      cur_buf_q, cur_buf_d;
    logic [4*PIX_W-1:0] shadow_q, shadow_d;
    logic [CXW-1:0]     cx_q, cx_d;                   // cell column of the next pixel to load
    logic [CSW-1:0]     sx_q, sx_d;                   // pixel column inside the cell
    logic [CSW-1:0]     sy_q, sy_d;                   // pixel line inside the cell row
    logic [AW-1:0]      cy_q, cy_d;                   // cell row being drawn
    logic               uflag_q, uflag_d;             // waiting in R_LOAD counts as underrun
    logic [15:0]        underrun_q, underrun_d;
    logic               tvalid_q, tvalid_d;
    logic [PIX_W-1:0]   tdata_q, tdata_d;
    logic               tlast_q, tlast_d;
    logic               tuser_q, tuser_d;
    logic               frame_done_q, frame_done_d;

    logic [BPC-1:0]     cell_val_s;
    logic [1:0]         pal_idx_s;
    logic [PIX_W-1:0]   pix_s;
    logic               end_x_s, end_sy_s, end_cy_s, first_s;

    // Colour of the pixel addressed by the render counters, plus position flags
    always_comb begin
        cell_val_s = BPC'(cur_buf_q >> ((X_CELLS - 1 - int'(cx_q)) * BPC));
        pal_idx_s  = 2'(cell_val_s);
        case (pal_idx_s)
            2'd0:    pix_s = shadow_q[0*PIX_W +: PIX_W];
            2'd1:    pix_s = shadow_q[1*PIX_W +: PIX_W];
            2'd2:    pix_s = shadow_q[2*PIX_W +: PIX_W];
            2'd3:    pix_s = shadow_q[3*PIX_W +: PIX_W];
            default: pix_s = shadow_q[0*PIX_W +: PIX_W];
        endcase
        end_x_s  = (cx_q == CXW'(X_CELLS - 1)) && (sx_q == CSW'(CELL_SIZE - 1));
        end_sy_s = (sy_q == CSW'(CELL_SIZE - 1));
        end_cy_s = (cy_q == AW'(Y_CELLS - 1));
        first_s  = (cx_q == '0) && (sx_q == '0) && (sy_q == '0) && (cy_q == '0);
    end

    // Next-state logic: fetch FSM first, render FSM may override shared flags
    always_comb begin
        f_state_d    = f_state_q;
        r_state_d    = r_state_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        fetch_addr_d = fetch_addr_q;
        need_row_d   = need_row_q;
        drop_rsp_d   = drop_rsp_q;
        nxt_full_d   = nxt_full_q;
        nxt_buf_d    = nxt_buf_q;
        cur_buf_d    = cur_buf_q;
        shadow_d     = shadow_q;
        cx_d         = cx_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        cy_d         = cy_q;
        uflag_d      = uflag_q;
        underrun_d   = underrun_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        frame_done_d = 1'b0;

        case (f_state_q)
            F_IDLE: begin
                if (need_row_q && !nxt_full_q) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = fetch_addr_q;
                    need_row_d  = 1'b0;
                    f_state_d   = F_REQ;
                end else begin
                    f_state_d = F_IDLE;
                end
            end
            F_REQ: begin
                if (row_req_ready) begin
                    req_valid_d = 1'b0;
                    f_state_d   = F_WAIT;
                end else begin
                    f_state_d = F_REQ;
                end
            end
            F_WAIT: begin
                if (row_rsp_valid) begin
                    if (drop_rsp_q) begin
                        drop_rsp_d = 1'b0;
                    end else begin
                        nxt_buf_d  = row_rsp_data;
                        nxt_full_d = 1'b1;
                    end
                    f_state_d = F_IDLE;
                end else begin
                    f_state_d = F_WAIT;
                end
            end
            default: f_state_d = F_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: begin
                tvalid_d = 1'b0;
                if (enable) begin
                    shadow_d     = palette;
                    need_row_d   = 1'b1;
                    fetch_addr_d = '0;
                    uflag_d      = 1'b0;
                    r_state_d    = R_LOAD;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_LOAD: begin
                // a beat still held from the previous row may complete here
                if (tvalid_q && out_stream_tready) begin
                    tvalid_d = 1'b0;
                end else begin
                    tvalid_d = tvalid_q;
                end
                if (nxt_full_q) begin
                    cur_buf_d    = nxt_buf_q;
                    nxt_full_d   = 1'b0;
                    need_row_d   = 1'b1;
                    fetch_addr_d = (fetch_addr_q == AW'(Y_CELLS - 1)) ? '0 : fetch_addr_q + AW'(1);
                    uflag_d      = 1'b0;
                    r_state_d    = R_ACTIVE;
                end else if (uflag_q && (underrun_q != 16'hFFFF)) begin
                    underrun_d = underrun_q + 16'd1;
                end else begin
                    underrun_d = underrun_q;
                end
            end
            R_ACTIVE: begin
                if (!tvalid_q || out_stream_tready) begin
                    tvalid_d = 1'b1;
                    tdata_d  = pix_s;
                    tlast_d  = end_x_s;
                    tuser_d  = first_s;
                    if (!end_x_s) begin
                        if (sx_q == CSW'(CELL_SIZE - 1)) begin
                            sx_d = '0;
                            cx_d = cx_q + CXW'(1);
                        end else begin
                            sx_d = sx_q + CSW'(1);
                        end
                    end else begin
                        sx_d = '0;
                        cx_d = '0;
                        if (!end_sy_s) begin
                            sy_d = sy_q + CSW'(1);
                        end else begin
                            sy_d = '0;
                            if (end_cy_s) begin
                                cy_d      = '0;
                                r_state_d = R_DRAIN;
                            end else begin
                                cy_d = cy_q + AW'(1);
                                if (nxt_full_q) begin
                                    cur_buf_d    = nxt_buf_q;
                                    nxt_full_d   = 1'b0;
                                    need_row_d   = 1'b1;
                                    fetch_addr_d = (fetch_addr_q == AW'(Y_CELLS - 1)) ? '0 : fetch_addr_q + AW'(1);
                                end else begin
                                    uflag_d   = 1'b1;
                                    r_state_d = R_LOAD;
                                end
                            end
                        end
                    end
                end else begin
                    tvalid_d = tvalid_q;
                end
            end
            R_DRAIN: begin
                // wait for the last beat of the frame to be taken
                if (tvalid_q && out_stream_tready) begin
                    tvalid_d     = 1'b0;
                    frame_done_d = 1'b1;
                    if (enable) begin
                        shadow_d  = palette;
                        uflag_d   = 1'b0;
                        r_state_d = R_LOAD;
                    end else begin
                        nxt_full_d = 1'b0;
                        need_row_d = 1'b0;
                        drop_rsp_d = (f_state_d != F_IDLE);
                        r_state_d  = R_IDLE;
                    end
                end else begin
                    r_state_d = R_DRAIN;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State, buffers and registered outputs; periph_reset clears everything
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            f_state_q    <= F_IDLE;
            r_state_q    <= R_IDLE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            fetch_addr_q <= '0;
            need_row_q   <= 1'b0;
            drop_rsp_q   <= 1'b0;
            nxt_full_q   <= 1'b0;
            nxt_buf_q    <= '0;
            cur_buf_q    <= '0;
            shadow_q     <= '0;
            cx_q         <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            cy_q         <= '0;
            uflag_q      <= 1'b0;
            underrun_q   <= 16'd0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            f_state_q    <= f_state_d;
            r_state_q    <= r_state_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            fetch_addr_q <= fetch_addr_d;
            need_row_q   <= need_row_d;
            drop_rsp_q   <= drop_rsp_d;
            nxt_full_q   <= nxt_full_d;
            nxt_buf_q    <= nxt_buf_d;
            cur_buf_q    <= cur_buf_d;
            shadow_q     <= shadow_d;
            cx_q         <= cx_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            cy_q         <= cy_d;
            uflag_q      <= uflag_d;
            underrun_q   <= underrun_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_req_valid     = req_valid_q;
    assign row_req_addr      = req_addr_q;
    assign out_stream_tdata  = tdata_q;
    assign out_stream_tvalid = tvalid_q;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tuser  = tuser_q;
    assign frame_done        = frame_done_q;
    assign underrun_count    = underrun_q;
endmodule

// File: tb/tb_cell_grid_stream_gen.sv
// Scoreboard bench for cell_grid_stream_gen on a small 4x3 grid of 2-bit
// cells. Expected beats come from a pixel-coordinate reference model.
module tb_cell_grid_stream_gen;
    localparam int XC = 4, YC = 3, CS = 2, BPC = 2, PW = 24;
    localparam int RW = XC * BPC, AW = $clog2(YC), FW = XC * CS, FH = YC * CS;
    localparam int BUDGET = 30000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            periph_reset, enable;
    logic [4*PW-1:0] palette;
    logic            row_req_valid, row_req_ready;
    logic [AW-1:0]   row_req_addr;
    logic            row_rsp_valid;
    logic [RW-1:0]   row_rsp_data;
    logic [PW-1:0]   tdata;
    logic            tvalid, tready, tlast, tuser, frame_done;
    logic [15:0]     underrun_count;

    cell_grid_stream_gen #(.X_CELLS(XC), .Y_CELLS(YC), .CELL_SIZE(CS), .BPC(BPC), .PIX_W(PW)) dut (
        .out_stream_aclk(clk), .periph_reset(periph_reset), .enable(enable), .palette(palette),
        .row_req_valid(row_req_valid), .row_req_ready(row_req_ready), .row_req_addr(row_req_addr),
        .row_rsp_valid(row_rsp_valid), .row_rsp_data(row_rsp_data),
        .out_stream_tdata(tdata), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
        .out_stream_tlast(tlast), .out_stream_tuser(tuser), .frame_done(frame_done),
        .underrun_count(underrun_count));

    int            checks = 0, errors = 0;
    int            cells [YC][XC];
    logic [PW-1:0] pal_e [4];
    logic [PW+1:0] exp_q [$];
    int            fd_cnt = 0, beat_cnt = 0;
    int            lat = 2;
    bit            rand_tready = 1'b0;
    bit            store_flush = 1'b0, inject_stale = 1'b0;
    int            due_q [$];
    logic [RW-1:0] dat_q [$];
    int            cyc = 0;
    logic          held = 1'b0;
    logic [PW+1:0] held_v, mon_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Pack a grid row into the store word: cell 0 in the MSBs
    function automatic logic [RW-1:0] row_word(input int r);
        logic [RW-1:0] w;
        w = '0;
        for (int c = 0; c < XC; c++) w[(XC-1-c)*BPC +: BPC] = BPC'(cells[r][c]);
        return w;
    endfunction

    // Reference model: one frame of beats from pixel coordinates
    task automatic push_frame();
        logic [PW-1:0] col;
        for (int py = 0; py < FH; py++) begin
            for (int px = 0; px < FW; px++) begin
                col = pal_e[cells[py / CS][px / CS]];
                exp_q.push_back({col, px == FW - 1, (px == 0) && (py == 0)});
            end
        end
    endtask

    task automatic randomize_grid();
        for (int r = 0; r < YC; r++)
            for (int c = 0; c < XC; c++) cells[r][c] = $urandom_range(0, 3);
    endtask

    task automatic randomize_pal();
        for (int k = 0; k < 4; k++) pal_e[k] = PW'($urandom);
        palette = {pal_e[3], pal_e[2], pal_e[1], pal_e[0]};
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tdata"}, tdata, 0);
        chk({tag, "_tlast"}, tlast, 0);
        chk({tag, "_tuser"}, tuser, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_underrun"}, underrun_count, 0);
        chk({tag, "_req_valid"}, row_req_valid, 0);
        chk({tag, "_req_addr"}, row_req_addr, 0);
    endtask

    // Run n frames; enable is dropped during the last one
    task automatic run_frames(input int n, input bit change_pal);
        int base, b0, i;
        base = fd_cnt;
        b0   = beat_cnt;
        for (int f = 0; f < n; f++) push_frame();
        enable = 1'b1;
        i = 0;
        if (n == 1) begin
            while (beat_cnt == b0 && i < BUDGET) begin cycles(1); i++; end
        end else begin
            while (fd_cnt < base + n - 1 && i < BUDGET) begin cycles(1); i++; end
        end
        if (change_pal) randomize_pal();
        enable = 1'b0;
        i = 0;
        while (fd_cnt < base + n && i < BUDGET) begin cycles(1); i++; end
        chk("frame_done_count", fd_cnt - base, n);
        cycles(lat + 20);
        chk("queue_drained", exp_q.size(), 0);
        chk("tvalid_idle", tvalid, 0);
        chk("req_valid_idle", row_req_valid, 0);
        chk("frame_done_no_extra", fd_cnt - base, n);
    endtask

    // Row store: accepts requests, answers after lat cycles
    initial begin
        row_req_ready = 1'b0;
        row_rsp_valid = 1'b0;
        row_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (row_req_valid && row_req_ready && !periph_reset) begin
                due_q.push_back(cyc + lat);
                dat_q.push_back(row_word(int'(row_req_addr)));
            end
            @(posedge clk);
            #1;
            cyc++;
            row_rsp_valid = 1'b0;
            if (store_flush) begin
                due_q.delete();
                dat_q.delete();
                store_flush = 1'b0;
            end
            if (inject_stale) begin
                row_rsp_valid = 1'b1;
                row_rsp_data  = ~row_word(0);
                inject_stale  = 1'b0;
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                row_rsp_valid = 1'b1;
                row_rsp_data  = dat_q.pop_front();
                due_q.delete(0);
            end
            row_req_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Downstream ready: held high or random 50%
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tready = rand_tready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: stability while stalled, beat compare against the scoreboard
    always @(negedge clk) begin
        if (periph_reset) begin
            held = 1'b0;
        end else begin
            mon_cur = {tdata, tlast, tuser};
            if (held) chk("hold_stable", {tvalid, mon_cur}, {1'b1, held_v});
            if (tvalid && tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", mon_cur);
                end else begin
                    chk("beat", mon_cur, exp_q.pop_front());
                end
                held = 1'b0;
            end else if (tvalid) begin
                held   = 1'b1;
                held_v = mon_cur;
            end else begin
                held = 1'b0;
            end
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        int i;
        periph_reset = 1'b1;
        enable       = 1'b0;
        palette      = '0;
        cycles(3);
        check_outputs_zero("reset");
        periph_reset = 1'b0;

        // fixed row 0 = 00_01_10_11, tready held high, short latency
        randomize_grid();
        for (int c = 0; c < XC; c++) cells[0][c] = c;
        randomize_pal();
        lat = 2;
        rand_tready = 1'b0;
        run_frames(2, 1'b0);
        chk("underrun_fast", underrun_count, 0);

        // random backpressure, palette changed mid second frame
        randomize_grid();
        randomize_pal();
        rand_tready = 1'b1;
        run_frames(2, 1'b1);
        chk("underrun_fast_bp", underrun_count, 0);

        // slow store forces underruns at cell-row boundaries
        randomize_grid();
        lat = 400;
        run_frames(1, 1'b0);
        chk("underrun_nonzero", underrun_count != 16'd0, 1);

        // reset mid-line with a request outstanding
        randomize_grid();
        randomize_pal();
        lat = 50;
        push_frame();
        enable = 1'b1;
        i = beat_cnt;
        for (int k = 0; k < BUDGET && beat_cnt == i; k++) cycles(1);
        for (int k = 0; k < BUDGET && due_q.size() == 0; k++) cycles(1);
        chk("req_outstanding", due_q.size() > 0, 1);
        periph_reset = 1'b1;
        enable = 1'b0;
        cycles(1);
        periph_reset = 1'b0;
        check_outputs_zero("midreset");
        exp_q.delete();
        store_flush  = 1'b1;
        inject_stale = 1'b1;
        cycles(lat + 20);
        run_frames(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
